spigot_digit_rx: RTL
====================

# spigot_digit_rx

Consumer end of the spigot digit stream. Accepts packed BCD digit pairs (upper nibble first digit, lower nibble second digit) over a valid/ready handshake and buffers them in a small FIFO. Serializes them into an ASCII character stream for a downstream byte sink such as a UART TX or debug port. Optionally inserts a decimal point after the first digit since reset ("2.718..."). Non-BCD pairs are discarded and counted.

## Interface

Parameters:
- DEPTH, 4: FIFO entries (pairs); power of two, >= 2.
- INSERT_DOT, 1: when 1, emit ASCII '.' (0x2E) once, immediately after the first digit character since reset.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  in_digits holds a pair.
- in_ready  out  1  block can accept a pair this cycle.
- in_digits  in  8  [7:4] first digit, [3:0] second digit, BCD.
- out_valid  out  1  out_data holds a character.
- out_ready  in  1  sink accepts out_data this cycle.
- out_data  out  8  ASCII character.
- err_count  out  8  count of dropped non-BCD pairs; saturates at 255.

## Operation

- Input handshake: pair accepted when in_valid && in_ready. in_ready = !fifo_full && !reset.
- Validity check: if either nibble > 9, the pair is not written. err_count increments by 1 (holds at 255) and in_ready is unaffected.
- FIFO: DEPTH x 8. Pointers wrap modulo DEPTH. Occupancy counter is 0..DEPTH.
- No push when full, even if a pop occurs in the same cycle. Push and pop in the same non-full, non-empty cycle leaves occupancy unchanged.
- Output FSM states:
  - IDLE: out_valid=0. If FIFO non-empty: pop pair into hold register, go to HI.
  - HI: out_data = 0x30 + hold[7:4]. On out_ready: go to DOT if INSERT_DOT && !dot_done, else LO.
  - DOT: out_data = 0x2E. On out_ready: set dot_done, go to LO.
  - LO: out_data = 0x30 + hold[3:0]. On out_ready: if FIFO non-empty, pop the next pair into hold and go to HI in the same edge (no bubble); else go to IDLE.
- out_valid = 1 in HI, DOT and LO. out_data and out_valid are registered. Both hold stable while out_valid && !out_ready.
- dot_done is set once and cleared only by reset.

## Timing

- Reset values: in_ready=0 while reset is high, then 1 in the first cycle after release. out_valid=0, out_data=0x00, err_count=0, FIFO empty, FSM in IDLE, dot_done=0.
- Latency: pair accepted in cycle N into an empty FIFO with the FSM in IDLE gives out_valid=1 with the first digit in cycle N+2.
- Throughput: with out_ready held high, 1 character per cycle sustained; 2 cycles per pair, 3 for the first pair when the dot is inserted.
- Input sustains 1 pair/cycle until full. With continuous output drain, the steady state is 1 pair per 2 cycles.
- Reset asserted mid-character: out_valid drops immediately (asynchronous). Buffered pairs are lost, dot_done is cleared, and the next pair emits a dot again.
- Invalid pair while full: not accepted, because in_ready=0, so not counted. Only accepted handshakes are checked.

## Test plan

- Single pair: push 0x27 with out_ready=1 -> in cycles N+2, N+3, N+4, out_data = 0x32, 0x2E, 0x37; out_valid low at N+5.
- Streaming: push 0x27, 0x18, 0x28 back-to-back with out_ready=1 -> "2.71828" contiguous with no gaps. Then push 0x18 -> "18" with no dot.
- Backpressure/full: out_ready=0, push 6 pairs -> first pop into the hold register occurs, DEPTH further pairs buffer, then in_ready=0. Release out_ready -> all pairs emitted in order, none lost or duplicated.
- Invalid BCD: push 0x3A, then 0xF1, then 0x45 -> only "45" emitted; err_count=2. Push 300 invalid pairs -> err_count=255.
- Stall hold: out_ready=0 for 10 cycles during HI -> out_data=0x32 stable throughout; releases to the next character on the cycle after out_ready=1.
- Reset mid-stream: assert reset during LO with 3 pairs buffered -> out_valid=0 at once. After release, push 0x99 -> "9.9" (dot re-armed).

Source files
------------

// File: rtl/spigot_digit_rx.sv
// spigot_digit_rx
// Receives packed BCD digit pairs over a valid/ready handshake and buffers
// them in a small FIFO. Each pair is turned into two ASCII characters for a
// byte sink, optionally with a single '.' after the first digit since reset.
// Pairs holding a non-BCD nibble are dropped and counted (saturating).
module spigot_digit_rx #(
  parameter int DEPTH      = 4,
  parameter int INSERT_DOT = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_digits,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [7:0] err_count
);

  localparam int         AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] C_FULL  = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_EMPTY = (AW+1)'(0);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);
  localparam logic [AW-1:0] C_PTR_ONE = AW'(1);
  localparam logic       C_DOT_EN = (INSERT_DOT != 32'sd0);
  localparam logic [7:0] C_ASCII_DOT = 8'h2E;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HI   = 2'd1,
    ST_DOT  = 2'd2,
    ST_LO   = 2'd3
  } state_t;

  // A nibble is a decimal digit only when it is 0..9.
  function automatic logic is_bcd(input logic [3:0] nib);
    return (nib <= 4'd9);
  endfunction

  // Both digits of a pair must be decimal for the pair to be kept.
  function automatic logic pair_ok(input logic [7:0] pair);
    return is_bcd(pair[7:4]) && is_bcd(pair[3:0]);
  endfunction

  // ASCII '0' plus the digit value.
  function automatic logic [7:0] to_ascii(input logic [3:0] nib);
    return 8'h30 + {4'h0, nib};
  endfunction

  // FIFO storage and bookkeeping
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [AW:0]   w_count_next;

  // Error counter
  logic [7:0]    r_err_count;

  // Output serializer
  state_t        r_state;
  state_t        w_state_next;
  logic [7:0]    r_hold;
  logic [7:0]    w_hold_next;
  logic [7:0]    r_out_data;
  logic [7:0]    w_data_next;
  logic          r_out_valid;
  logic          w_valid_next;
  logic          r_dot_done;
  logic          w_dot_next;

  // Handshake / FIFO control
  logic          w_full;
  logic          w_empty;
  logic          w_accept;
  logic          w_pair_ok;
  logic          w_push;
  logic          w_pop;
  logic [7:0]    w_rd_data;

  assign w_full    = (r_count == C_FULL);
  assign w_empty   = (r_count == C_EMPTY);
  // Ready is withheld while reset is high so nothing is taken during reset.
  assign in_ready  = !w_full && !reset;
  assign w_accept  = in_valid && in_ready;
  assign w_pair_ok = pair_ok(in_digits);
  assign w_push    = w_accept && w_pair_ok;
  assign w_rd_data = r_mem[r_rd_ptr];

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign err_count = r_err_count;

  // Occupancy next value: a simultaneous push and pop cancel out.
  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + C_ONE;
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - C_ONE;
    end else begin
      w_count_next = r_count;
    end
  end

  // FIFO storage writes, pointer advance and occupancy register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 8'h00;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= C_EMPTY;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_digits;
        r_wr_ptr        <= r_wr_ptr + C_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + C_PTR_ONE;
      end
      r_count <= w_count_next;
    end
  end

  // Saturating count of accepted pairs that were rejected as non-BCD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_err_count <= 8'h00;
    end else if (w_accept && !w_pair_ok && (r_err_count != 8'hFF)) begin
      r_err_count <= r_err_count + 8'd1;
    end else begin
      r_err_count <= r_err_count;
    end
  end

  // Serializer next state: output data/valid are computed one cycle ahead
  // so they can be registered; LO chains directly into HI when more pairs
  // are waiting, giving one character per cycle with no bubble.
  always_comb begin
    w_state_next = r_state;
    w_hold_next  = r_hold;
    w_data_next  = r_out_data;
    w_valid_next = r_out_valid;
    w_dot_next   = r_dot_done;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_hold_next  = w_rd_data;
          w_data_next  = to_ascii(w_rd_data[7:4]);
          w_valid_next = 1'b1;
          w_state_next = ST_HI;
        end else begin
          w_valid_next = 1'b0;
        end
      end
      ST_HI: begin
        if (out_ready) begin
          if (C_DOT_EN && !r_dot_done) begin
            w_data_next  = C_ASCII_DOT;
            w_state_next = ST_DOT;
          end else begin
            w_data_next  = to_ascii(r_hold[3:0]);
            w_state_next = ST_LO;
          end
        end else begin
          w_state_next = ST_HI;
        end
      end
      ST_DOT: begin
        if (out_ready) begin
          w_dot_next   = 1'b1;
          w_data_next  = to_ascii(r_hold[3:0]);
          w_state_next = ST_LO;
        end else begin
          w_state_next = ST_DOT;
        end
      end
      ST_LO: begin
        if (out_ready) begin
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_hold_next  = w_rd_data;
            w_data_next  = to_ascii(w_rd_data[7:4]);
            w_state_next = ST_HI;
          end else begin
            w_valid_next = 1'b0;
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_LO;
        end
      end
      default: begin
        w_valid_next = 1'b0;
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Serializer state, hold register, registered outputs and dot flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_hold      <= 8'h00;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
      r_dot_done  <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_hold      <= w_hold_next;
      r_out_data  <= w_data_next;
      r_out_valid <= w_valid_next;
      r_dot_done  <= w_dot_next;
    end
  end

endmodule
